// File: rtl/stack_ctx_engine.sv
`timescale 1ns/1ps
// stack_ctx_engine: pushes or pops an N_WORDS-word context frame (flags ..
// PC) over the shared data-memory bus. The engine samples SP with start and
// returns the updated SP; it never owns the stack pointer itself. Each frame
// is bounds-checked against [STACK_LIMIT, STACK_TOP] before any bus traffic.
module stack_ctx_engine #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                N_WORDS     = 2,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'h80,
  parameter logic [ADDR_W-1:0] STACK_TOP   = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_pop,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic [ADDR_W-1:0]         sp_in,
  output logic [ADDR_W-1:0]         sp_out,
  output logic                      sp_we,
  input  logic [N_WORDS*DATA_W-1:0] ctx_in,
  output logic [N_WORDS*DATA_W-1:0] ctx_out,
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_dout,
  input  logic [DATA_W-1:0]         mem_din,
  input  logic                      bus_grant
);

  localparam int CTX_W = N_WORDS * DATA_W;
  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [CNT_W-1:0]  LAST_K = CNT_W'(N_WORDS - 1);
  localparam logic [ADDR_W:0]   N_EXT  = (ADDR_W + 1)'(N_WORDS);
  localparam logic [ADDR_W-1:0] N_ADDR = ADDR_W'(N_WORDS);
  localparam logic [ADDR_W:0]   ONE_EXT   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LIMIT_EXT = {1'b0, STACK_LIMIT};
  localparam logic [ADDR_W:0]   TOP_EXT   = {1'b0, STACK_TOP};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_XFER,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] sp_q;
  logic              pop_q;
  logic [CTX_W-1:0]  ctx_q;   // push words still to be sent, word 0 at the bottom
  logic [CNT_W-1:0]  cnt_q;

  // Bounds check is done one bit wider than the address so that neither
  // sp - N_WORDS nor sp + N_WORDS - 1 can wrap and fake a legal frame.
  logic [ADDR_W:0]  sp_ext;
  logic             push_ok;
  logic             pop_ok;
  logic             frame_ok;
  logic [CTX_W-1:0] ctx_next;

  assign sp_ext   = {1'b0, sp_q};
  assign push_ok  = (sp_ext >= N_EXT) && ((sp_ext - N_EXT) >= LIMIT_EXT);
  assign pop_ok   = (sp_ext + N_EXT - ONE_EXT) <= TOP_EXT;
  assign frame_ok = pop_q ? pop_ok : push_ok;
  assign ctx_next = ctx_q >> DATA_W;

  // Control FSM with every bus and handshake output registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sp_q     <= '0;
      pop_q    <= 1'b0;
      ctx_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sp_we    <= 1'b0;
      sp_out   <= '0;
      ctx_out  <= '0;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the register values from before this edge; the default pulse
      // clears below are overridden by any later assignment in the case.
      done  <= 1'b0;
      err   <= 1'b0;
      sp_we <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            sp_q  <= sp_in;
            pop_q <= op_pop;
            ctx_q <= ctx_in;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          cnt_q <= '0;
          if (frame_ok) begin
            mem_req  <= 1'b1;
            mem_wr   <= ~pop_q;
            mem_addr <= pop_q ? sp_q : sp_q - ADDR_W'(1);
            if (!pop_q) begin
              mem_dout <= ctx_q[DATA_W-1:0];
            end
            state <= S_XFER;
          end else begin
            // Rejected frame: no bus traffic, SP and context left untouched.
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_DONE;
          end
        end

        S_XFER: begin
          if (bus_grant) begin
            // Popped words go straight into ctx_out; words not yet read keep
            // their old contents, which is all a consumer may rely on anyway.
            if (pop_q) begin
              ctx_out[(int'(LAST_K) - int'(cnt_q)) * DATA_W +: DATA_W] <= mem_din;
            end
            if (cnt_q == LAST_K) begin
              mem_req <= 1'b0;
              mem_wr  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              sp_we   <= 1'b1;
              sp_out  <= pop_q ? sp_q + N_ADDR : sp_q - N_ADDR;
              state   <= S_DONE;
            end else begin
              cnt_q    <= cnt_q + CNT_W'(1);
              mem_addr <= pop_q ? mem_addr + ADDR_W'(1) : mem_addr - ADDR_W'(1);
              if (!pop_q) begin
                ctx_q    <= ctx_next;
                mem_dout <= ctx_next[DATA_W-1:0];
              end
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctx_engine.sv
`timescale 1ns/1ps
// tb_stack_ctx_engine: two engines (2-word and 4-word frames) share one
// behavioural bus slave. Stimulus pushes expected bus accesses and completion
// results into queues from a frame-level model; a negedge monitor plays the
// memory, pops the queues and compares.
module tb_stack_ctx_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start2, start4, op_pop, bus_grant;
  logic [7:0]  sp_in, mem_din;
  logic [31:0] ctx_in;

  logic        busy2, done2, err2, sp_we2, req2, wr2;
  logic [7:0]  sp_out2, addr2, dout2;
  logic [15:0] ctx_out2;
  logic        busy4, done4, err4, sp_we4, req4, wr4;
  logic [7:0]  sp_out4, addr4, dout4;
  logic [31:0] ctx_out4;

  stack_ctx_engine #(.N_WORDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_pop(op_pop), .busy(busy2),
    .done(done2), .err(err2), .sp_in(sp_in), .sp_out(sp_out2), .sp_we(sp_we2),
    .ctx_in(ctx_in[15:0]), .ctx_out(ctx_out2), .mem_req(req2), .mem_wr(wr2),
    .mem_addr(addr2), .mem_dout(dout2), .mem_din(mem_din), .bus_grant(bus_grant)
  );

  stack_ctx_engine #(.N_WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_pop(op_pop), .busy(busy4),
    .done(done4), .err(err4), .sp_in(sp_in), .sp_out(sp_out4), .sp_we(sp_we4),
    .ctx_in(ctx_in), .ctx_out(ctx_out4), .mem_req(req4), .mem_wr(wr4),
    .mem_addr(addr4), .mem_dout(dout4), .mem_din(mem_din), .bus_grant(bus_grant)
  );

  typedef struct {
    int          dut;
    bit          err;
    logic [7:0]  sp;
    logic [31:0] ctx;
    int          start_cyc;
  } exp_t;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  exp_t        exp_q[$];
  acc_t        bus_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  ref_mem[256];
  logic [7:0]  model_sp[2];
  logic [31:0] model_ctx[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int grant_mode = 0;   // 0 always grant, 1 random, 2 stall the first stall_left requests
  int stall_left = 0;
  int stalls     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: legality from plain integer arithmetic, memory as
  // an array, context words mapped flags-first.
  task automatic model_issue(input int d, input bit pop, input logic [7:0] sp,
                             input logic [31:0] ctx, input int scyc);
    int          n;
    bit          legal;
    logic [7:0]  a;
    logic [31:0] c;
    exp_t        e;
    n = d ? 4 : 2;
    legal = pop ? ((int'(sp) + n - 1) <= 255) : ((int'(sp) - n) >= 128);
    e.dut = d;
    e.start_cyc = scyc;
    e.err = !legal;
    if (legal && !pop) begin
      for (int k = 0; k < n; k++) begin
        a = 8'(int'(sp) - 1 - k);
        ref_mem[a] = ctx[k*8 +: 8];
        bus_q.push_back('{1'b1, a, ctx[k*8 +: 8]});
      end
      model_sp[d] = 8'(int'(sp) - n);
    end else if (legal) begin
      c = model_ctx[d];
      for (int k = 0; k < n; k++) begin
        a = 8'(int'(sp) + k);
        c[(n-1-k)*8 +: 8] = ref_mem[a];
        bus_q.push_back('{1'b0, a, 8'h00});
      end
      model_ctx[d] = c;
      model_sp[d] = 8'(int'(sp) + n);
    end
    e.sp  = model_sp[d];
    e.ctx = model_ctx[d];
    exp_q.push_back(e);
  endtask

  task automatic handle_done(input int d);
    exp_t e;
    int   n;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done: dut=%0d actual=done expected=no done", d);
    end else begin
      e = exp_q.pop_front();
      n = d ? 4 : 2;
      check("done_dut", d, e.dut);
      check("err", d ? err4 : err2, e.err);
      check("sp_we", d ? sp_we4 : sp_we2, !e.err);
      check("busy_at_done", d ? busy4 : busy2, 0);
      check("sp_out", d ? sp_out4 : sp_out2, e.sp);
      check("ctx_out", d ? ctx_out4 : {16'h0, ctx_out2}, e.ctx);
      check("latency", cyc - e.start_cyc, e.err ? 2 : n + 2 + stalls);
    end
    stalls = 0;
  endtask

  // Bus slave and result monitor, evaluated away from the active edge.
  logic       prev_stall = 1'b0;
  logic       prev_wr;
  logic [7:0] prev_addr, prev_dout;
  always @(negedge clk) begin
    logic       req, wr, g;
    logic [7:0] addr, dout;
    acc_t       a;
    req  = req2 | req4;
    wr   = req4 ? wr4 : wr2;
    addr = req4 ? addr4 : addr2;
    dout = req4 ? dout4 : dout2;
    if (rst) begin
      bus_grant  = 1'b0;
      prev_stall = 1'b0;
      stalls     = 0;
    end else begin
      if (prev_stall) begin
        check("hold_req", req, 1);
        check("hold_addr", addr, prev_addr);
        check("hold_wr", wr, prev_wr);
        if (wr) check("hold_dout", dout, prev_dout);
      end
      case (grant_mode)
        0: g = 1'b1;
        1: g = ($urandom_range(0, 9) < 7);
        default: begin
          if (req && stall_left > 0) begin
            g = 1'b0;
            stall_left--;
          end else begin
            g = 1'b1;
          end
        end
      endcase
      bus_grant = g;
      if (req && !g) stalls++;
      if (req && g) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_access: actual addr=%0h wr=%0b expected=no access", addr, wr);
        end else begin
          a = bus_q.pop_front();
          check("acc_wr", wr, a.wr);
          check("acc_addr", addr, a.addr);
          if (a.wr) check("acc_data", dout, a.data);
        end
        if (wr) mem[addr] = dout;
        else    mem_din = mem[addr];
      end
      prev_stall = req && !g;
      prev_addr  = addr;
      prev_dout  = dout;
      prev_wr    = wr;
      if (done2) handle_done(0);
      if (done4) handle_done(1);
    end
  end

  // One operation; poke > 0 pulses a second start poke cycles after the real one.
  task automatic run_op(input int d, input bit pop, input logic [7:0] sp,
                        input logic [31:0] ctx, input int poke);
    int budget;
    @(posedge clk); #1;
    model_issue(d, pop, sp, ctx, cyc);
    op_pop = pop;
    sp_in  = sp;
    ctx_in = ctx;
    if (d != 0) start4 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    start4 = 1'b0;
    if (poke > 0) begin
      repeat (poke - 1) begin
        @(posedge clk); #1;
      end
      op_pop = ~pop;
      sp_in  = 8'hC0;
      if (d != 0) start4 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      start4 = 1'b0;
    end
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: actual=no done after 300 cycles expected=done (dut=%0d)", d);
      exp_q.delete();
      bus_q.delete();
    end
  endtask

  task automatic zero_models();
    for (int d = 0; d < 2; d++) begin
      model_sp[d]  = 8'h00;
      model_ctx[d] = 32'h0;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  a;
    bit          found;
    start2 = 1'b0; start4 = 1'b0; op_pop = 1'b0;
    sp_in = 8'h00; ctx_in = 32'h0; bus_grant = 1'b0; mem_din = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v[7:0];
      ref_mem[i] = v[7:0];
    end
    zero_models();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy", {busy2, busy4}, 0);
    check("rst_done", {done2, done4}, 0);
    check("rst_err", {err2, err4}, 0);
    check("rst_sp_we", {sp_we2, sp_we4}, 0);
    check("rst_mem_req", {req2, req4}, 0);
    check("rst_mem_wr", {wr2, wr4}, 0);
    check("rst_mem_addr", {addr2, addr4}, 0);
    check("rst_mem_dout", {dout2, dout4}, 0);
    check("rst_sp_out", {sp_out2, sp_out4}, 0);
    check("rst_ctx_out", {ctx_out2, ctx_out4}, 0);

    // 2-word frames: push, pop back, both bound violations.
    run_op(0, 1'b0, 8'hF0, 32'h0000_3C15, 0);
    check("mem_EF_flags", mem[8'hEF], 8'h15);
    check("mem_EE_pc", mem[8'hEE], 8'h3C);
    run_op(0, 1'b1, 8'hEE, 32'h0, 0);
    run_op(0, 1'b0, 8'h81, 32'h0000_BEEF, 0);
    run_op(0, 1'b1, 8'hFF, 32'h0, 0);

    // Word 0 stalled three cycles, with a start pulse landing while busy.
    grant_mode = 2;
    stall_left = 3;
    run_op(0, 1'b0, 8'hE0, 32'h0000_A55A, 2);
    grant_mode = 0;

    // Start presented in the done cycle must be dropped.
    run_op(0, 1'b0, 8'hD0, 32'h0000_1234, 4);

    // 4-word round trip.
    run_op(1, 1'b0, 8'hC0, 32'h1122_3344, 0);
    run_op(1, 1'b1, 8'hBC, 32'h0, 0);
    check("rt_ctx4", ctx_out4, 32'h1122_3344);

    // Reset during the word 1 access of a 4-word push.
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      a = 8'(8'hD0 - 1 - k);
      v = 32'hDEAD_BEEF;
      ref_mem[a] = v[k*8 +: 8];
      bus_q.push_back('{1'b1, a, v[k*8 +: 8]});
    end
    op_pop = 1'b0;
    sp_in  = 8'hD0;
    ctx_in = 32'hDEAD_BEEF;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #1;
      if (req4 && addr4 == 8'hCE) found = 1'b1;
    end
    check("abort_word1_seen", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    zero_models();
    @(negedge clk);
    check("abort_mem_req", req4, 0);
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_sp_out", sp_out4, 0);
    check("abort_accesses_left", bus_q.size(), 0);
    bus_q.delete();
    run_op(1, 1'b0, 8'hB0, 32'hCAFE_F00D, 0);
    run_op(1, 1'b1, 8'hAC, 32'h0, 0);

    // Randomised traffic around the stack window edges.
    for (int i = 0; i < 60; i++) begin
      int          d;
      bit          pop;
      logic [7:0]  sp;
      logic [31:0] ctx;
      d   = $urandom_range(0, 1);
      pop = 1'($urandom_range(0, 1));
      sp  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(120, 255));
      ctx = $urandom;
      grant_mode = $urandom_range(0, 1);
      run_op(d, pop, sp, ctx, 0);
    end
    grant_mode = 0;

    repeat (10) @(posedge clk);
    check("queues_drained", exp_q.size() + bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctx_engine.md
Name: stack_ctx_engine

Overview:
Parametrised successor to the MiniRISC CPU stack controller. It pushes or pops an N_WORDS-word context frame (flags, PC and optional extra registers) over the shared data-memory bus. It adds a start/done handshake, bounds checking against a configurable stack window, and an error report. It sits between the control unit (interrupt entry, RTI, CALL/RET) and the data-memory arbiter. The engine never owns SP: it reads SP and returns the updated value.

Parameters:
DATA_W, 8, width of one stack word and memory data bus
ADDR_W, 8, memory address width
N_WORDS, 2, context words per frame (1..8); word 0 = flags, word N_WORDS-1 = PC
STACK_LIMIT, 8'h80, lowest legal stack address (inclusive)
STACK_TOP, 8'hFF, highest legal stack address (inclusive)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle operation request; sampled only in IDLE
op_pop  in  1  0 = push, 1 = pop; sampled with start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  valid with done: operation rejected by bounds check
sp_in  in  ADDR_W  current SP (points at last pushed word); sampled with start
sp_out  out  ADDR_W  updated SP; valid from the done cycle, held until the next done
sp_we  out  1  equals done & ~err; control unit loads sp_out into SP
ctx_in  in  N_WORDS*DATA_W  context to push; word k at bits [k*DATA_W +: DATA_W]; latched on start
ctx_out  out  N_WORDS*DATA_W  popped context; valid from the done cycle of a pop, held afterwards
mem_req  out  1  bus request
mem_wr  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  access address
mem_dout  out  DATA_W  write data
mem_din  in  DATA_W  read data; valid in the grant cycle
bus_grant  in  1  access completes in any cycle where mem_req & bus_grant

Behaviour:
- Reset values: state IDLE; busy, done, err, sp_we, mem_req and mem_wr = 0; mem_addr, mem_dout, sp_out and ctx_out = 0; word counter = 0.
- States:
  - IDLE: on start, latch sp_in, op_pop and ctx_in, then go to CHECK.
  - CHECK: one cycle, no bus activity, busy = 1. Go to XFER if the frame is legal, else to DONE with err set.
  - XFER: one memory access per word.
  - DONE: one cycle, done = 1, then return to IDLE.
- Bounds checks use ADDR_W+1-bit arithmetic, with no wrap:
  - Push is legal iff sp - N_WORDS >= STACK_LIMIT.
  - Pop is legal iff sp + N_WORDS - 1 <= STACK_TOP.
- Push, counter k = 0..N_WORDS-1:
  - mem_addr = sp - 1 - k, mem_dout = ctx word k.
  - Flags therefore land at sp-1 and PC at sp-N_WORDS.
  - sp_out = sp - N_WORDS.
- Pop, counter k = 0..N_WORDS-1:
  - mem_addr = sp + k; on the grant cycle, capture mem_din into ctx word N_WORDS-1-k.
  - sp_out = sp + N_WORDS.
- Bus timing in XFER:
  - mem_req is held high with stable mem_addr, mem_dout and mem_wr until bus_grant.
  - On grant, the counter increments and the next word is presented in the following cycle.
  - After the last grant, mem_req drops in the next cycle and the engine enters DONE.
  - Minimum latency from start to done: N_WORDS + 2 cycles with bus_grant held high.
- Outputs outside XFER: mem_req = 0. mem_addr and mem_dout hold the last driven value so the arbiter sees no glitching mux.
- Error path:
  - No memory access occurs.
  - sp_out and ctx_out are unchanged; sp_we = 0.
  - done and err pulse together.
- start while busy or in DONE: ignored, not queued.
- start in the same cycle as done: ignored; the requester must wait for IDLE (busy low and done low).
- Reset mid-transfer: return to IDLE immediately; the frame is partially written or read with no done; SP is not updated.
- ctx_out bits of words not yet read keep their previous values until the pop completes.
- Addresses are computed modulo 2^ADDR_W; the legality check guarantees no wrap on a legal frame.

Test Plan:
- N_WORDS=2, sp_in=8'hF0, push ctx={PC=8'h3C, flags=8'h15}, bus_grant=1 -> writes 8'h15@EF then 8'h3C@EE; done at start+4; sp_out=8'hEE; sp_we=1; err=0.
- Pop with sp_in=8'hEE, memory as above -> reads EE then EF; ctx_out={8'h3C, 8'h15}; sp_out=8'hF0; done at start+4.
- Push with sp_in=8'h81, STACK_LIMIT=8'h80, N_WORDS=2 -> err=1 and done at start+2; mem_req never high; sp_we=0.
- Pop with sp_in=8'hFF -> err=1 (FF+1 > STACK_TOP); ctx_out unchanged.
- bus_grant low for 3 cycles on word 0 of a push -> mem_addr and mem_dout stable throughout; done delayed by 3 cycles; a start pulse while busy is ignored.
- N_WORDS=4 push then pop, round-trip {8'h11, 8'h22, 8'h33, 8'h44}; then rst asserted during the word 1 access of a further push -> mem_req=0 and state IDLE next cycle; no done; a subsequent push completes normally.
